bus_memory_responder: RTL
=========================

// Module: bus_memory_responder
// PURPOSE
//  Memory-side responder for the CPU control-unit bus: accepts read/write requests
//  (addr_lo/addr_hi, read, write, enable), services them from an on-chip byte array
//  after a programmable number of wait states, and returns rdata with a one-cycle ready.
//  Sits between the CU and program/data storage; the top region is write-protected ROM.
// PARAMETERS
//  ADDR_W       10       implemented array depth = 2**ADDR_W bytes; index = addr[ADDR_W-1:0] (mirrored)
//  WAIT_STATES  1        extra cycles between accept and response (0..15)
//  ROM_BASE     16'hFF00 full 16-bit addresses >= ROM_BASE are read-only
// PORTS
//  clk      in   1  system clock, rising edge
//  reset    in   1  asynchronous, active-low reset
//  addr_lo  in   8  request address [7:0] (CU pcl)
//  addr_hi  in   8  request address [15:8] (CU pch)
//  read     in   1  read request qualifier
//  write    in   1  write request qualifier
//  enable   in   1  bus cycle strobe
//  wdata    in   8  write data
//  rdata    out  8  read data, valid when ready=1 on a read
//  ready    out  1  one-cycle completion pulse
//  busy     out  1  high from accept until the ready cycle inclusive
//  fault    out  1  one-cycle pulse with ready: ROM write or read&write both set
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, rdata=8'h00, ready=0, busy=0, fault=0,
//    wait counter=0; array contents not cleared. Reset mid-op aborts; pending write not committed.
//  - FSM: IDLE -> WAIT -> RESPOND -> IDLE. WAIT skipped when WAIT_STATES=0.
//  - IDLE: accept when enable=1 and (read|write). Latch addr={addr_hi,addr_lo}, wdata, op.
//    Next state WAIT (cnt loaded WAIT_STATES-1) or RESPOND. busy=1 from next cycle.
//  - WAIT: decrement cnt; at cnt==0 -> RESPOND. Bus inputs ignored (latched copy used).
//  - RESPOND: ready=1 for exactly one cycle, then IDLE.
//      read : rdata <= array[addr[ADDR_W-1:0]], registered, presented with ready.
//      write: array written this cycle unless addr>=ROM_BASE (then no write, fault=1).
//      read&write both at accept: no array access, rdata unchanged, fault=1.
//  - rdata holds last read value between reads; writes never change rdata.
//  - Latency: ready asserted WAIT_STATES+1 cycles after the accept edge.
//    Throughput: one request per WAIT_STATES+2 cycles (IDLE needed between requests).
//  - enable held or reasserted during WAIT/RESPOND is ignored; CU must hold or re-issue
//    after ready. Request present in IDLE right after RESPOND is accepted that cycle.
//  - Address wraps: array index ignores addr[15:ADDR_W]; ROM check uses full 16 bits.
//  - Write to 16'hFFFF with ROM_BASE=16'hFF00: faulted; write to 16'hFEFF: committed.
// STRUCTURE
//  - Shared package cpu_bus_pkg: FSM state encodings (IDLE/WAIT/RESPOND, 2 bits),
//    bus op encoding (OP_NONE/OP_READ/OP_WRITE/OP_BAD), default ROM_BASE constant.
//  - One sub-module: mem_array (single-port sync byte RAM, ADDR_W param, we/addr/wd/rd),
//    reusable for a later ROM-init variant. FSM, counter, latches, ROM check in top.
// TESTING
//  1 Reset: drive reset=0 mid-WAIT -> rdata=00, ready=0, busy=0, fault=0 immediately;
//    release, read 0x0010 -> returns value written before reset only if write had completed.
//  2 WAIT_STATES=1: write 0x0042<-8'hA5, then read 0x0042 -> ready 2 cycles after each
//    accept, rdata=8'hA5, fault=0.
//  3 WAIT_STATES=0: back-to-back reads 0x0000,0x0001 with enable held -> ready every 2nd cycle.
//  4 ROM: write 0xFF10<-8'h3C -> ready=1 & fault=1; read 0xFF10 -> old value, fault=0.
//    Write 0xFEFF<-8'h11 -> committed, fault=0.
//  5 Mirroring (ADDR_W=10): write 0x0405<-8'h77, read 0x0005 -> rdata=8'h77.
//  6 read=write=enable=1 -> ready=1, fault=1, rdata unchanged, no array write.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared encodings for the CPU control-unit bus.
//   state_t          - responder FSM states (2 bits)
//   op_t             - latched bus operation
//   ROM_BASE_DEFAULT - lowest write-protected address
//   decode_op        - maps the read/write qualifiers to an op_t
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_BAD   = 2'd3
  } op_t;

  localparam logic [15:0] ROM_BASE_DEFAULT = 16'hFF00;

  function automatic op_t decode_op(input logic rd, input logic wr);
    op_t op;
    case ({rd, wr})
      2'b10:   op = OP_READ;
      2'b01:   op = OP_WRITE;
      2'b11:   op = OP_BAD;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous byte RAM, read-first.
//   clk  - clock
//   we   - write enable
//   addr - byte index
//   wd   - write data
//   rd   - registered read data (contents of addr before any same-cycle write)
// No reset: contents survive a system reset.
module mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wd,
  output logic [7:0]        rd
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
    rd <= mem[addr];
  end

endmodule

// File: rtl/bus_memory_responder.sv
// bus_memory_responder: memory-side responder for the CPU control-unit bus.
// Accepts a read/write in IDLE, waits WAIT_STATES cycles, then services it from
// an on-chip byte array and pulses ready. Addresses >= ROM_BASE are read-only.
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   addr_lo - request address [7:0]
//   addr_hi - request address [15:8]
//   read    - read qualifier
//   write   - write qualifier
//   enable  - bus cycle strobe
//   wdata   - write data
//   rdata   - read data, valid with ready on a read; holds last read value
//   ready   - one-cycle completion pulse
//   busy    - high from accept through the ready cycle
//   fault   - pulse with ready on ROM write or read&write request
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for enable with read or write
// ST_WAIT    | counting wait states on the latched request
// ST_RESPOND | array access; ready/fault registered this cycle
module bus_memory_responder
  import cpu_bus_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] ROM_BASE    = ROM_BASE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr_lo,
  input  logic [7:0] addr_hi,
  input  logic       read,
  input  logic       write,
  input  logic       enable,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready,
  output logic       busy,
  output logic       fault
);

  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam state_t     ST_AFTER_ACCEPT = (WAIT_STATES > 0) ? ST_WAIT : ST_RESPOND;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  op_t         op_q;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;
  logic [7:0]  rdata_hold;
  logic [7:0]  mem_rd;
  logic        mem_we;
  logic        accept;
  logic        rom_hit;

  assign accept  = (state_q == ST_IDLE) && enable && (read || write);
  assign rom_hit = (addr_q >= ROM_BASE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    fault_d = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_AFTER_ACCEPT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESPOND;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        case (op_q)
          OP_WRITE: begin
            if (rom_hit) fault_d = 1'b1;
            else         mem_we  = 1'b1;
          end
          OP_BAD:  fault_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      op_q    <= OP_NONE;
    end else if (accept) begin
      addr_q  <= {addr_hi, addr_lo};
      wdata_q <= wdata;
      op_q    <= decode_op(read, write);
    end
  end

  // The RAM output register is shared with every access, so the read result
  // is captured into the hold register at the end of its ready cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              rdata_hold <= 8'h00;
    else if (ready_q && (op_q == OP_READ))   rdata_hold <= mem_rd;
  end

  mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr_q[ADDR_W-1:0]),
    .wd   (wdata_q),
    .rd   (mem_rd)
  );

  assign rdata = (ready_q && (op_q == OP_READ)) ? mem_rd : rdata_hold;
  assign ready = ready_q;
  assign fault = fault_q;
  assign busy  = (state_q != ST_IDLE) || ready_q;

endmodule
